// File: rtl/sram_phase_sequencer_pkg.sv
// Shared types for the frame phase sequencer: state encoding, bus widths and
// the UART-exit routing decision.
package sram_phase_sequencer_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [2:0] {
        S_SEQ_IDLE    = 3'd0,
        S_SEQ_UART_RX = 3'd1,
        S_SEQ_M2      = 3'd2,
        S_SEQ_M1      = 3'd3,
        S_SEQ_DONE    = 3'd4
    } seq_state_type;

    // Milestones that are not enabled are skipped; with neither enabled the
    // received image goes straight to display.
    function automatic seq_state_type uart_exit_state(input logic run_m2,
                                                      input logic run_m1);
        seq_state_type nxt;
        if (run_m2) begin
            nxt = S_SEQ_M2;
        end else if (run_m1) begin
            nxt = S_SEQ_M1;
        end else begin
            nxt = S_SEQ_DONE;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sram_phase_sequencer_sram_access_mux.sv
// Selects which requester owns the single SRAM port, from the registered
// sequencer state; VGA reads whenever no other phase is active.
module sram_access_mux
    import sram_phase_sequencer_pkg::*;
(
    input  seq_state_type            state,
    input  logic [SRAM_ADDR_W-1:0]   uart_address,
    input  logic [SRAM_DATA_W-1:0]   uart_write_data,
    input  logic                     uart_we_n,
    input  logic [SRAM_ADDR_W-1:0]   m2_address,
    input  logic [SRAM_DATA_W-1:0]   m2_write_data,
    input  logic                     m2_we_n,
    input  logic [SRAM_ADDR_W-1:0]   m1_address,
    input  logic [SRAM_DATA_W-1:0]   m1_write_data,
    input  logic                     m1_we_n,
    input  logic [SRAM_ADDR_W-1:0]   vga_address,
    output logic [SRAM_ADDR_W-1:0]   sram_address,
    output logic [SRAM_DATA_W-1:0]   sram_write_data,
    output logic                     sram_we_n
);

    always_comb begin
        sram_address    = vga_address;
        sram_write_data = '0;
        sram_we_n       = 1'b1;
        case (state)
            S_SEQ_UART_RX: begin
                sram_address    = uart_address;
                sram_write_data = uart_write_data;
                sram_we_n       = uart_we_n;
            end
            S_SEQ_M2: begin
                sram_address    = m2_address;
                sram_write_data = m2_write_data;
                sram_we_n       = m2_we_n;
            end
            S_SEQ_M1: begin
                sram_address    = m1_address;
                sram_write_data = m1_write_data;
                sram_we_n       = m1_we_n;
            end
            default: begin
                sram_address    = vga_address;
                sram_write_data = '0;
                sram_we_n       = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sram_phase_sequencer.sv
// Sequences one decode frame (UART receive -> M2 -> M1 -> display) and
// arbitrates the external SRAM port between the four requesters.
module sram_phase_sequencer
    import sram_phase_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int TIMER_WIDTH    = 26
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    UART_RX_I,
    input  logic                    run_m2,
    input  logic                    run_m1,
    input  logic [SRAM_ADDR_W-1:0]  uart_address,
    input  logic [SRAM_DATA_W-1:0]  uart_write_data,
    input  logic                    uart_we_n,
    input  logic [SRAM_ADDR_W-1:0]  m2_address,
    input  logic [SRAM_DATA_W-1:0]  m2_write_data,
    input  logic                    m2_we_n,
    input  logic                    m2_done,
    input  logic [SRAM_ADDR_W-1:0]  m1_address,
    input  logic [SRAM_DATA_W-1:0]  m1_write_data,
    input  logic                    m1_we_n,
    input  logic                    m1_done,
    input  logic [SRAM_ADDR_W-1:0]  vga_address,
    output logic                    UART_rx_initialize,
    output logic                    UART_rx_enable,
    output logic                    M2_start,
    output logic                    M1_start,
    output logic                    VGA_enable,
    output logic [SRAM_ADDR_W-1:0]  SRAM_address,
    output logic [SRAM_DATA_W-1:0]  SRAM_write_data,
    output logic                    SRAM_we_n,
    output logic [2:0]              phase,
    output logic                    frame_done
);

    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    seq_state_type            state_q, state_d;
    logic [TIMER_WIDTH-1:0]   timer_q, timer_d;
    logic                     rx_init_q, rx_init_d;
    logic                     rx_enable_q, rx_enable_d;
    logic                     m2_start_q, m2_start_d;
    logic                     m1_start_q, m1_start_d;
    logic                     vga_enable_q, vga_enable_d;
    logic                     frame_done_q, frame_done_d;
    // Marks the first cycle of a milestone phase, when its done may be stale.
    logic                     first_q, first_d;
    seq_state_type            exit_state;

    assign exit_state = uart_exit_state(run_m2, run_m1);

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        rx_init_d    = rx_init_q;
        rx_enable_d  = rx_enable_q;
        m2_start_d   = m2_start_q;
        m1_start_d   = m1_start_q;
        vga_enable_d = vga_enable_q;
        frame_done_d = frame_done_q;
        first_d      = first_q;

        case (state_q)
            S_SEQ_IDLE: begin
                if (!UART_RX_I) begin
                    state_d      = S_SEQ_UART_RX;
                    rx_init_d    = 1'b1;
                    vga_enable_d = 1'b0;
                    timer_d      = '0;
                end
            end

            S_SEQ_UART_RX: begin
                if (rx_init_q) begin
                    rx_init_d   = 1'b0;
                    rx_enable_d = 1'b1;
                end
                if (!uart_we_n) begin
                    timer_d = '0;
                end else if (timer_q == TIMEOUT_LAST) begin
                    rx_enable_d = 1'b0;
                    timer_d     = '0;
                    state_d     = exit_state;
                    case (exit_state)
                        S_SEQ_M2: begin
                            m2_start_d = 1'b1;
                            first_d    = 1'b1;
                        end
                        S_SEQ_M1: begin
                            m1_start_d = 1'b1;
                            first_d    = 1'b1;
                        end
                        default: frame_done_d = 1'b1;
                    endcase
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_SEQ_M2: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else if (m2_done) begin
                    m2_start_d = 1'b0;
                    if (run_m1) begin
                        state_d    = S_SEQ_M1;
                        m1_start_d = 1'b1;
                        first_d    = 1'b1;
                    end else begin
                        state_d      = S_SEQ_DONE;
                        frame_done_d = 1'b1;
                    end
                end
            end

            S_SEQ_M1: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else if (m1_done) begin
                    m1_start_d   = 1'b0;
                    state_d      = S_SEQ_DONE;
                    frame_done_d = 1'b1;
                end
            end

            S_SEQ_DONE: begin
                frame_done_d = 1'b0;
                vga_enable_d = 1'b1;
                state_d      = S_SEQ_IDLE;
            end

            default: begin
                state_d = S_SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_SEQ_IDLE;
            timer_q      <= '0;
            rx_init_q    <= 1'b0;
            rx_enable_q  <= 1'b0;
            m2_start_q   <= 1'b0;
            m1_start_q   <= 1'b0;
            vga_enable_q <= 1'b1;
            frame_done_q <= 1'b0;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            rx_init_q    <= rx_init_d;
            rx_enable_q  <= rx_enable_d;
            m2_start_q   <= m2_start_d;
            m1_start_q   <= m1_start_d;
            vga_enable_q <= vga_enable_d;
            frame_done_q <= frame_done_d;
            first_q      <= first_d;
        end
    end

    assign UART_rx_initialize = rx_init_q;
    assign UART_rx_enable     = rx_enable_q;
    assign M2_start           = m2_start_q;
    assign M1_start           = m1_start_q;
    assign VGA_enable         = vga_enable_q;
    assign frame_done         = frame_done_q;
    assign phase              = state_q;

    sram_access_mux u_sram_access_mux (
        .state           (state_q),
        .uart_address    (uart_address),
        .uart_write_data (uart_write_data),
        .uart_we_n       (uart_we_n),
        .m2_address      (m2_address),
        .m2_write_data   (m2_write_data),
        .m2_we_n         (m2_we_n),
        .m1_address      (m1_address),
        .m1_write_data   (m1_write_data),
        .m1_we_n         (m1_we_n),
        .vga_address     (vga_address),
        .sram_address    (SRAM_address),
        .sram_write_data (SRAM_write_data),
        .sram_we_n       (SRAM_we_n)
    );

endmodule

// File: doc/sram_phase_sequencer.md
# sram_phase_sequencer

Top-level controller that sequences one image-decode frame (UART receive → milestone 2 → milestone 1 → VGA display) and owns the single external SRAM port on behalf of all four requesters. It replaces the ad-hoc phase logic and SRAM address/write muxing at top level. The UART phase ends on a true receive timeout, not immediately. The block sits between the UART/M1/M2/VGA units and SRAM_controller.

## Interface
- TIMEOUT_CYCLES, 50_000_000: idle cycles on UART (no SRAM write) that end reception.
- TIMER_WIDTH, 26: width of the timeout counter; TIMEOUT_CYCLES ≤ 2^TIMER_WIDTH.
- Clock  in  1  system clock (50 MHz).
- Reset  in  1  asynchronous, active-high reset.
- UART_RX_I  in  1  raw UART line; low = start bit.
- run_m2, run_m1  in  1 each  phase enables; sampled at phase transitions.
- uart_address / uart_write_data / uart_we_n  in  18/16/1  UART requester.
- m2_address / m2_write_data / m2_we_n / m2_done  in  18/16/1/1  M2 requester.
- m1_address / m1_write_data / m1_we_n / m1_done  in  18/16/1/1  M1 requester.
- vga_address  in  18  VGA requester (read only).
- UART_rx_initialize, UART_rx_enable  out  1 each  UART interface control.
- M2_start, M1_start  out  1 each  level start, held for the whole phase.
- VGA_enable  out  1  display enable.
- SRAM_address / SRAM_write_data / SRAM_we_n  out  18/16/1  to SRAM_controller.
- phase  out  3  current state encoding.
- frame_done  out  1  one-cycle pulse at end of frame.

## Operation
- States: S_SEQ_IDLE(0), S_SEQ_UART_RX(1), S_SEQ_M2(2), S_SEQ_M1(3), S_SEQ_DONE(4).
- Reset values: state IDLE, VGA_enable=1, all other outputs 0 except SRAM_we_n=1; timer=0; SRAM_address=vga_address.
- IDLE: UART_RX_I==0 → UART_rx_initialize<=1, VGA_enable<=0, timer<=0, go UART_RX. UART_RX_I is ignored in every other state.
- UART_RX, first cycle (initialize=1): initialize<=0, UART_rx_enable<=1. Enable is then held until exit.
- UART_RX, each cycle: timer+1. If uart_we_n==0 that cycle, timer<=0 instead (the write takes priority over the increment).
- UART_RX exit: when timer==TIMEOUT_CYCLES-1, UART_rx_enable<=0, timer<=0, and next state is M2 if run_m2, else M1 if run_m1, else DONE. The matching start output goes high on the same edge.
- M2: M2_start=1. m2_done is ignored in the first cycle of the phase (stale done). Afterwards m2_done=1 → M2_start<=0, then go M1 (M1_start<=1) if run_m1, else DONE.
- M1: same rule with m1_done/M1_start; exit to DONE.
- DONE: lasts one cycle. frame_done=1; VGA_enable<=1; go IDLE.
- Done inputs from the non-active milestone are ignored.
- SRAM mux is combinational from the registered state:
  - UART_RX → uart_* signals.
  - M2 → m2_* signals.
  - M1 → m1_* signals.
  - otherwise → vga_address, SRAM_we_n=1, SRAM_write_data=0.
- Reset asserted mid-phase: everything returns to reset values immediately (asynchronous). Starts drop and the partially processed frame is abandoned.

## Timing
- IDLE→UART_RX: 1 cycle after the UART_RX_I low sample.
- initialize is high for exactly 1 cycle; UART_rx_enable rises the following cycle.
- UART phase exit: exactly TIMEOUT_CYCLES cycles after the last uart_we_n==0 cycle, or after entry if no write occurs.
- Milestone done→next phase start: 1 cycle. There is no SRAM dead cycle; the mux switches on the same edge as the start outputs.
- Milestone phase minimum length: 2 cycles.
- frame_done rises 1 cycle after the last done is accepted.
- VGA_enable is high again in the first IDLE cycle.

## Structure
- seq_state_type enum (5 states, 3-bit encoding as above) is added to define_state.h alongside top_state_type.
- SRAM requester mux is the natural sub-module: sram_access_mux (combinational, select = state).
- Timer and FSM stay in sram_phase_sequencer.

## Test plan
All scenarios use TIMEOUT_CYCLES=100.
- Reset with UART_RX_I=1 → phase=0, VGA_enable=1, SRAM_we_n=1, SRAM_address=vga_address (drive 18'h23E00 and check it passes through).
- UART_RX_I low at cycle 10; uart_we_n pulses at cycles 20 and 50.
  - Required: initialize high at 11 only; enable high from 12.
  - Required: phase moves to 2 exactly 100 cycles after the cycle-50 write; M2_start rises on the same edge.
- m2_done held high from phase entry.
  - Required: ignored in the first cycle; accepted in the second.
  - Required: M2_start falls, M1_start rises 1 cycle later, SRAM_address switches to m1_address (e.g. 18'h00100).
- run_m2=0, run_m1=0 → UART_RX goes to DONE; frame_done pulses exactly once; VGA_enable=1 in the next cycle.
- Reset asserted mid-M1 (m1_we_n=0 driven) → asynchronously phase=0, M1_start=0, SRAM_we_n=1, with no clock edge required.
- m1_done asserted during M2 → no effect; phase stays 2 until m2_done.
